// File: rtl/pipe_hazard_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// pipe_pkg
// Types and constants shared by the hazard controller, its forwarding unit and
// its interface.
//   hz_state_t : controller FSM states
//   fwd_sel_t  : EX-stage operand source select
//   REG_ZERO   : architectural x0, which never creates a dependency
//   fwd_pick() : forwarding priority for a single operand
// ----------------------------------------------------------------------------
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    DRAIN    = 2'd2,
    DRAINED  = 2'd3
  } hz_state_t;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_MEM = 2'b01,
    FWD_WB  = 2'b10
  } fwd_sel_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // MEM holds the younger result, so it beats WB when both match.
  function automatic fwd_sel_t fwd_pick(input logic [4:0] rs,
                                        input logic [4:0] rd_m,
                                        input logic       wr_m,
                                        input logic [4:0] rd_w,
                                        input logic       wr_w);
    if (wr_m && (rd_m != REG_ZERO) && (rd_m == rs))
      return FWD_MEM;
    else if (wr_w && (rd_w != REG_ZERO) && (rd_w == rs))
      return FWD_WB;
    else
      return FWD_RF;
  endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl_if
// Bundle between the 5-stage pipeline datapath and the hazard controller.
//   master : pipeline side, drives register ids / status, receives controls
//   slave  : controller side
// Signals: rs1_D/rs2_D, rs1_E/rs2_E, rd_E/rd_M/rd_W with their write enables,
// mem_rd_E, br_taken_E, dmem_req_M/dmem_ready_M, drain_req (to controller);
// stall_F/D/E/M, flush_D/E/W, fwd_a_E/fwd_b_E, drain_done, mem_timeout
// (from controller).
// ----------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
  import pipe_pkg::*;

  logic [4:0] rs1_D, rs2_D;
  logic [4:0] rs1_E, rs2_E;
  logic [4:0] rd_E, rd_M, rd_W;
  logic       reg_wr_E, mem_rd_E;
  logic       reg_wr_M, reg_wr_W;
  logic       br_taken_E;
  logic       dmem_req_M, dmem_ready_M;
  logic       drain_req;

  logic       stall_F, stall_D, stall_E, stall_M;
  logic       flush_D, flush_E, flush_W;
  fwd_sel_t   fwd_a_E, fwd_b_E;
  logic       drain_done;
  logic       mem_timeout;

  modport master (
    output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           reg_wr_E, mem_rd_E, reg_wr_M, reg_wr_W, br_taken_E,
           dmem_req_M, dmem_ready_M, drain_req,
    input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwd_a_E, fwd_b_E, drain_done, mem_timeout
  );

  modport slave (
    input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
           reg_wr_E, mem_rd_E, reg_wr_M, reg_wr_W, br_taken_E,
           dmem_req_M, dmem_ready_M, drain_req,
    output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
           fwd_a_E, fwd_b_E, drain_done, mem_timeout
  );

endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// ----------------------------------------------------------------------------
// hazard_fwd_unit
// Purely combinational EX-stage forwarding selects and load-use detection.
// Ports:
//   rs1_D, rs2_D          in  sources of the instruction in ID
//   rs1_E, rs2_E          in  sources of the instruction in EX
//   rd_E, reg_wr_E,
//   mem_rd_E              in  EX destination / write enable / is-load
//   rd_M, reg_wr_M        in  MEM destination / write enable
//   rd_W, reg_wr_W        in  WB destination / write enable
//   fwd_a, fwd_b          out operand source selects
//   lu                    out load in EX feeds the instruction in ID
// ----------------------------------------------------------------------------
module hazard_fwd_unit
  import pipe_pkg::*;
(
  input  logic [4:0] rs1_D,
  input  logic [4:0] rs2_D,
  input  logic [4:0] rs1_E,
  input  logic [4:0] rs2_E,
  input  logic [4:0] rd_E,
  input  logic       reg_wr_E,
  input  logic       mem_rd_E,
  input  logic [4:0] rd_M,
  input  logic       reg_wr_M,
  input  logic [4:0] rd_W,
  input  logic       reg_wr_W,
  output fwd_sel_t   fwd_a,
  output fwd_sel_t   fwd_b,
  output logic       lu
);

  assign fwd_a = fwd_pick(rs1_E, rd_M, reg_wr_M, rd_W, reg_wr_W);
  assign fwd_b = fwd_pick(rs2_E, rd_M, reg_wr_M, rd_W, reg_wr_W);

  assign lu = mem_rd_E && reg_wr_E && (rd_E != REG_ZERO) &&
              ((rd_E == rs1_D) || (rd_E == rs2_D));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// ----------------------------------------------------------------------------
// pipe_hazard_ctrl
// Central stall/flush/forwarding controller for the 5-stage RV32 pipeline,
// with an FSM for data-memory wait states and pipeline drain requests.
// Ports:
//   clk      in  clock, rising edge
//   reset    in  asynchronous, active-high; forces every output to 0
//   hz       slave side of pipe_hazard_ctrl_if
//   perf_lu, perf_mwait, perf_brflush  out 32-bit wrapping event counters,
//            present only when HAZ_PERF_CNT_EN is defined
// Parameters:
//   MEM_TIMEOUT   wait cycles after which the sticky mem_timeout is set
//   DRAIN_CYCLES  bubble cycles for E/M/W to retire during a drain
//
// state    | meaning
// ---------+----------------------------------------------------------------
// RUN      | normal flow; branch flush and load-use stall handled here
// MEM_WAIT | data memory not ready; whole pipe frozen, WB bubbled
// DRAIN    | front end held, bubbles injected until E/M/W have retired
// DRAINED  | pipeline empty, drain_done held until drain_req drops
// ----------------------------------------------------------------------------
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MEM_TIMEOUT  = 64,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic clk,
  input  logic reset,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZ_PERF_CNT_EN
  ,
  output logic [31:0] perf_lu,
  output logic [31:0] perf_mwait,
  output logic [31:0] perf_brflush
`endif
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam int DRN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_MAX  = TMO_W'(MEM_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(MEM_TIMEOUT - 1);
  localparam logic [DRN_W-1:0] DRN_LAST = DRN_W'(DRAIN_CYCLES - 1);

  hz_state_t        state, state_nxt, ret_state, ret_nxt, eff_state;
  logic [TMO_W-1:0] tmo_cnt, tmo_nxt;
  logic [DRN_W-1:0] drn_cnt, drn_nxt;
  logic             mem_timeout_q, tmo_set;
  logic             mwait, lu;
  fwd_sel_t         fwd_a, fwd_b;
  logic             st_f, st_d, st_e, st_m, fl_d, fl_e, fl_w, done_c;

  hazard_fwd_unit u_fwd (
    .rs1_D    (hz.rs1_D),
    .rs2_D    (hz.rs2_D),
    .rs1_E    (hz.rs1_E),
    .rs2_E    (hz.rs2_E),
    .rd_E     (hz.rd_E),
    .reg_wr_E (hz.reg_wr_E),
    .mem_rd_E (hz.mem_rd_E),
    .rd_M     (hz.rd_M),
    .reg_wr_M (hz.reg_wr_M),
    .rd_W     (hz.rd_W),
    .reg_wr_W (hz.reg_wr_W),
    .fwd_a    (fwd_a),
    .fwd_b    (fwd_b),
    .lu       (lu)
  );

  assign mwait = hz.dmem_req_M && !hz.dmem_ready_M;

  // While waiting, the state we came from still governs the first cycle
  // after the wait ends, so held branches and drain progress resume there.
  assign eff_state = (state == MEM_WAIT) ? ret_state : state;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= RUN;
      ret_state     <= RUN;
      tmo_cnt       <= '0;
      drn_cnt       <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
      tmo_cnt   <= tmo_nxt;
      drn_cnt   <= drn_nxt;
      if (tmo_set) mem_timeout_q <= 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    tmo_nxt   = tmo_cnt;
    drn_nxt   = drn_cnt;
    tmo_set   = 1'b0;
    st_f = 1'b0; st_d = 1'b0; st_e = 1'b0; st_m = 1'b0;
    fl_d = 1'b0; fl_e = 1'b0; fl_w = 1'b0;
    done_c = 1'b0;

    if (mwait) begin
      st_f = 1'b1; st_d = 1'b1; st_e = 1'b1; st_m = 1'b1;
      fl_w = 1'b1;
      done_c    = (eff_state == DRAINED);
      state_nxt = MEM_WAIT;
      if (state != MEM_WAIT) ret_nxt = state;
      if (tmo_cnt != TMO_MAX) tmo_nxt = tmo_cnt + 1'b1;
      // Set together with the counter reaching MEM_TIMEOUT.
      if (tmo_cnt == TMO_LAST) tmo_set = 1'b1;
    end else begin
      tmo_nxt   = '0;
      state_nxt = eff_state;
      case (eff_state)
        RUN: begin
          if (hz.br_taken_E) begin
            fl_d = 1'b1;
            fl_e = 1'b1;
          end else if (lu) begin
            st_f = 1'b1;
            st_d = 1'b1;
            fl_e = 1'b1;
          end
          if (hz.drain_req) begin
            state_nxt = DRAIN;
            drn_nxt   = '0;
          end
        end
        DRAIN: begin
          st_f = 1'b1;
          fl_e = 1'b1;
          // Flush wins over hold on IF/ID.
          st_d = !hz.br_taken_E;
          fl_d = hz.br_taken_E;
          drn_nxt = drn_cnt + 1'b1;
          if (!hz.drain_req)
            state_nxt = RUN;
          else if (drn_cnt == DRN_LAST)
            state_nxt = DRAINED;
        end
        DRAINED: begin
          done_c = 1'b1;
          st_f   = 1'b1;
          fl_e   = 1'b1;
          st_d   = !hz.br_taken_E;
          fl_d   = hz.br_taken_E;
          if (!hz.drain_req) state_nxt = RUN;
        end
        default: state_nxt = RUN;
      endcase
    end
  end

  // Outputs are forced low for as long as reset is asserted.
  assign hz.stall_F     = !reset && st_f;
  assign hz.stall_D     = !reset && st_d;
  assign hz.stall_E     = !reset && st_e;
  assign hz.stall_M     = !reset && st_m;
  assign hz.flush_D     = !reset && fl_d;
  assign hz.flush_E     = !reset && fl_e;
  assign hz.flush_W     = !reset && fl_w;
  assign hz.drain_done  = !reset && done_c;
  assign hz.mem_timeout = !reset && mem_timeout_q;
  assign hz.fwd_a_E     = reset ? FWD_RF : fwd_a;
  assign hz.fwd_b_E     = reset ? FWD_RF : fwd_b;

`ifdef HAZ_PERF_CNT_EN
  logic perf_lu_inc, perf_br_inc;

  assign perf_lu_inc = !mwait && (eff_state == RUN) && !hz.br_taken_E && lu;
  assign perf_br_inc = !mwait && (eff_state == RUN) && hz.br_taken_E;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_lu      <= '0;
      perf_mwait   <= '0;
      perf_brflush <= '0;
    end else begin
      if (perf_lu_inc) perf_lu      <= perf_lu + 32'd1;
      if (mwait)       perf_mwait   <= perf_mwait + 32'd1;
      if (perf_br_inc) perf_brflush <= perf_brflush + 32'd1;
    end
  end
`endif

endmodule
